// File: rtl/sm4_pkg.sv
// sm4_pkg
// Shared SM4 definitions used by the cipher round, the key schedule and the
// composite transform unit: mode encodings, FSM state encoding, 32-bit rotate
// and the two linear transforms L (cipher rounds) and L' (key expansion).
// No ports; imported with "import sm4_pkg::*".
package sm4_pkg;

   typedef enum logic [1:0] {
      MODE_TAU  = 2'b00,
      MODE_L    = 2'b01,
      MODE_LK   = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SUB  = 2'b01,
      OUT  = 2'b10
   } state_e;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] sm4L(input logic [31:0] b);
      return b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
   endfunction

   function automatic logic [31:0] sm4Lk(input logic [31:0] b);
      return b ^ rotl32(b, 13) ^ rotl32(b, 23);
   endfunction

   // The reserved mode falls through to plain tau so a stray encoding still
   // produces a well-defined word instead of an error.
   function automatic logic [31:0] applyMode(input mode_e mode, input logic [31:0] b);
      case (mode)
         MODE_L:  return sm4L(b);
         MODE_LK: return sm4Lk(b);
         default: return b;
      endcase
   endfunction

endpackage

// File: rtl/sm4_t_unit_sbox.sv
// S_BOX
// Purely combinational SM4 byte substitution, one lookup per instance.
// Ports:
//   a_i  input byte
//   b_o  substituted byte
module S_BOX (
   input  logic [7:0] a_i,
   output logic [7:0] b_o
);

   localparam logic [7:0] SBOX_TABLE [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   assign b_o = SBOX_TABLE[a_i];

endmodule

// File: rtl/sm4_t_unit.sv
// sm4_t_unit
// Handshaked SM4 composite transform: tau (byte-wise S-box) over a 32-bit
// word using LANES shared S-boxes over 4/LANES cycles, followed by L, L' or
// no linear transform. The result is held in a register until consumed.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_data [31:0]            word A, byte 0 = [31:24]
//   in_mode [1:0]             00 tau, 01 L(tau), 10 L'(tau), 11 as 00
//   out_valid/out_ready       result handshake
//   out_data [31:0]           registered result
module sm4_t_unit
   import sm4_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   localparam logic [1:0] LANE_STEP = 2'(LANES);
   localparam logic [1:0] LAST_CNT  = 2'(4 - LANES);

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4) begin : gBadLanes
         $error("sm4_t_unit: LANES must be 1, 2 or 4");
      end
   endgenerate

   state_e               state_q, state_d;
   mode_e                mode_q, mode_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [3:0][7:0]      work_q, work_d;
   logic [31:0]          outData_q, outData_d;
   logic                 outValid_q, outValid_d;
   logic [3:0][7:0]      subWord;
   logic [LANES-1:0][7:0] sboxIn;
   logic [LANES-1:0][7:0] sboxOut;
   logic                 accept;

   // Byte i of the word lives in work_q[3-i], so byte 0 is the MSB. Each lane
   // looks at the byte counter offset by its lane number.
   for (genvar l = 0; l < LANES; l++) begin : gLane
      logic [1:0] byteIdx;
      assign byteIdx    = cnt_q + 2'(l);
      assign sboxIn[l]  = work_q[2'd3 - byteIdx];
      S_BOX uSbox (
         .a_i (sboxIn[l]),
         .b_o (sboxOut[l])
      );
   end

   // Accepting while in OUT is allowed when the consumer is taking the
   // current result in the same cycle, which removes the idle bubble.
   assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;

   // Work word with this cycle's lane results merged in; on the final SUB
   // cycle this is the complete tau result feeding the linear transform.
   always_comb begin
      subWord = work_q;
      for (int l = 0; l < LANES; l++) begin
         subWord[2'd3 - (cnt_q + 2'(l))] = sboxOut[l];
      end
   end

   // Next-state logic: latch on accept, substitute LANES bytes per cycle,
   // transform and register on the last pass, then hold until consumed.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      outData_d  = outData_q;
      outValid_d = outValid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               work_d  = in_data;
               mode_d  = mode_e'(in_mode);
               cnt_d   = 2'd0;
               state_d = SUB;
            end
         end
         SUB: begin
            work_d = subWord;
            cnt_d  = cnt_q + LANE_STEP;
            if (cnt_q == LAST_CNT) begin
               outData_d  = applyMode(mode_q, subWord);
               outValid_d = 1'b1;
               state_d    = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
               if (in_valid) begin
                  work_d  = in_data;
                  mode_d  = mode_e'(in_mode);
                  cnt_d   = 2'd0;
                  state_d = SUB;
               end
            end
         end
         default: begin
            outValid_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_TAU;
         cnt_q      <= 2'd0;
         work_q     <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
      end
   end

endmodule

// File: tb/tb_sm4_t_unit.sv
// tb_sm4_t_unit
// Drives three instances (LANES = 1, 2, 4) with directed and random requests.
// Expected words are queued when a request is issued; a per-instance monitor
// pops and compares on every output handshake and checks latency and hold.
`timescale 1ns/1ps
module tb_sm4_t_unit;

   localparam int NINST = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid      [NINST];
   logic        inReady      [NINST];
   logic [31:0] inData       [NINST];
   logic [1:0]  inMode       [NINST];
   logic        outValid     [NINST];
   logic        outReadyMain [NINST];
   logic        outReadyRnd  [NINST];
   logic        randReady    [NINST];
   logic        outReady     [NINST];
   logic [31:0] outData      [NINST];

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [31:0] expQ [NINST][$];
   int          accQ [NINST][$];
   int          lastAccept [NINST];
   int          lastOutHs  [NINST];

   logic [7:0] sboxRef [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   always #5 clk = ~clk;

   // Cycle count equals the number of rising edges seen so far.
   always @(posedge clk) cycle <= cycle + 1;

   // Reference rotate taken from the doubled word, then the transforms.
   function automatic logic [31:0] refRotl(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x};
      return d[63-n -: 32];
   endfunction

   function automatic logic [31:0] refModel(input logic [31:0] a, input logic [1:0] mode);
      logic [31:0] b;
      b = {sboxRef[a[31:24]], sboxRef[a[23:16]], sboxRef[a[15:8]], sboxRef[a[7:0]]};
      if (mode == 2'b01)
         return b ^ refRotl(b, 2) ^ refRotl(b, 10) ^ refRotl(b, 18) ^ refRotl(b, 24);
      else if (mode == 2'b10)
         return b ^ refRotl(b, 13) ^ refRotl(b, 23);
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // Queue the expected word, present the request at a falling edge and
   // hold it until the unit takes it at the next rising edge.
   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [1:0] mode,
                                input logic [31:0] exp);
      int waited;
      expQ[idx].push_back(exp);
      inValid[idx] = 1'b1;
      inData[idx]  = a;
      inMode[idx]  = mode;
      waited = 0;
      #1;
      while (!inReady[idx] && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: inst %0d never raised in_ready", idx);
      end
      @(negedge clk);
      inValid[idx] = 1'b0;
      inData[idx]  = $urandom;
      inMode[idx]  = 2'($urandom_range(0, 3));
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", 32'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 32'd0);
   endtask

   for (genvar g = 0; g < NINST; g++) begin : gInst
      localparam int LN = 1 << g;
      localparam int NS = 4 / LN;

      logic        prevValid = 1'b0;
      logic        prevStall = 1'b0;
      logic [31:0] prevData  = '0;
      int          acc;

      assign outReady[g] = randReady[g] ? outReadyRnd[g] : outReadyMain[g];

      always @(negedge clk) outReadyRnd[g] <= 1'($urandom_range(0, 1));

      sm4_t_unit #(.LANES(LN)) uDut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (inValid[g]),
         .in_ready  (inReady[g]),
         .in_data   (inData[g]),
         .in_mode   (inMode[g]),
         .out_valid (outValid[g]),
         .out_ready (outReady[g]),
         .out_data  (outData[g])
      );

      // Monitor: samples just after each falling edge, when inputs are settled.
      initial begin
         forever begin
            @(negedge clk);
            #1;
            if (rst) begin
               prevValid = 1'b0;
               prevStall = 1'b0;
            end else begin
               if (inValid[g] && inReady[g]) begin
                  accQ[g].push_back(cycle + 1);
                  lastAccept[g] = cycle + 1;
               end
               if (outValid[g] && !prevValid) begin
                  if (accQ[g].size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL spurious_valid: inst %0d out_valid with no accepted request", g);
                  end else begin
                     acc = accQ[g].pop_front();
                     checkOutput($sformatf("latency_l%0d", LN), 32'(cycle - acc), 32'(NS));
                  end
               end
               if (prevStall) begin
                  checkOutput($sformatf("hold_data_l%0d", LN), outData[g], prevData);
                  checkOutput($sformatf("hold_valid_l%0d", LN), 32'(outValid[g]), 32'd1);
               end
               if (outValid[g] && !outReady[g])
                  checkOutput($sformatf("stall_in_ready_l%0d", LN), 32'(inReady[g]), 32'd0);
               if (outValid[g] && outReady[g]) begin
                  lastOutHs[g] = cycle + 1;
                  if (expQ[g].size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL extra_result: inst %0d got %h with nothing expected", g, outData[g]);
                  end else begin
                     checkOutput($sformatf("data_l%0d", LN), outData[g], expQ[g].pop_front());
                  end
               end
               prevValid = outValid[g];
               prevStall = outValid[g] && !outReady[g];
               prevData  = outData[g];
            end
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  m;
      for (int i = 0; i < NINST; i++) begin
         inValid[i]      = 1'b0;
         inData[i]       = '0;
         inMode[i]       = '0;
         outReadyMain[i] = 1'b1;
         randReady[i]    = 1'b0;
         lastAccept[i]   = -1;
         lastOutHs[i]    = -2;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < NINST; i++) begin
         checkOutput("reset_out_valid", 32'(outValid[i]), 32'd0);
         checkOutput("reset_out_data", outData[i], 32'd0);
         checkOutput("reset_in_ready", 32'(inReady[i]), 32'd1);
      end
      @(negedge clk);

      $display("[TB] directed vectors");
      applyStimulus(2, 32'h00000000, 2'b00, 32'hD6D6D6D6);
      applyStimulus(0, 32'h00000000, 2'b01, 32'h5B5B5B5B);
      applyStimulus(0, 32'h00000000, 2'b10, 32'h67676767);
      applyStimulus(1, 32'h01FF0000, 2'b00, 32'h9048D6D6);
      applyStimulus(1, 32'h01FF0000, 2'b11, 32'h9048D6D6);
      for (int i = 0; i < NINST; i++) begin
         applyStimulus(i, 32'h00010203, 2'b00, 32'hD690E9FE);
         applyStimulus(i, 32'hFEDCBA98, 2'b00, 32'h39B86AAD);
         applyStimulus(i, 32'h00000000, 2'b01, 32'h5B5B5B5B);
         applyStimulus(i, 32'h00000000, 2'b10, 32'h67676767);
         applyStimulus(i, 32'h01FF0000, 2'b11, 32'h9048D6D6);
      end
      waitDrain();

      $display("[TB] backpressure and back-to-back accept");
      outReadyMain[2] = 1'b0;
      applyStimulus(2, 32'hFEDCBA98, 2'b00, 32'h39B86AAD);
      repeat (5) begin
         @(negedge clk);
         #1;
         checkOutput("bp_out_valid", 32'(outValid[2]), 32'd1);
         checkOutput("bp_in_ready", 32'(inReady[2]), 32'd0);
         checkOutput("bp_out_data", outData[2], 32'h39B86AAD);
      end
      @(negedge clk);
      outReadyMain[2] = 1'b1;
      applyStimulus(2, 32'h00010203, 2'b00, 32'hD690E9FE);
      checkOutput("b2b_no_bubble", 32'(lastAccept[2]), 32'(lastOutHs[2]));
      waitDrain();

      $display("[TB] reset during substitution");
      applyStimulus(0, 32'h00010203, 2'b01, refModel(32'h00010203, 2'b01));
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NINST; i++) begin
         expQ[i].delete();
         accQ[i].delete();
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         checkOutput("rst_mid_out_valid", 32'(outValid[0]), 32'd0);
      end
      checkOutput("rst_mid_in_ready", 32'(inReady[0]), 32'd1);
      @(negedge clk);
      applyStimulus(0, 32'h00000000, 2'b10, 32'h67676767);
      waitDrain();

      $display("[TB] random requests with random out_ready");
      for (int i = 0; i < NINST; i++) begin
         randReady[i] = 1'b1;
         for (int k = 0; k < 8; k++) begin
            a = $urandom;
            m = 2'($urandom_range(0, 3));
            applyStimulus(i, a, m, refModel(a, m));
         end
         waitDrain();
         randReady[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sm4_t_unit.md
# sm4_t_unit

Parametrised, handshaked SM4 composite transform unit: the successor to the combinational four-S-box tau stage. It computes tau (byte-wise S-box substitution) over a 32-bit word using a configurable number of S-box lanes, time-multiplexed across cycles. It then applies a selectable linear transform: L for cipher rounds, L' for key expansion, or none. It sits between the round/key-schedule XOR datapath and the round register, so one S-box instance set can be shared by the cipher and key-schedule controllers.

## Interface
- `LANES`, 4: S-box instances, legal values 1, 2, 4; any other value is an elaboration error. Substitution takes NSUB = 4/LANES cycles.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `in_data`  in  32  word A; bit 31 is MSB; byte 0 = [31:24].
- `in_mode`  in  2  00 = tau only, 01 = L(tau(A)), 10 = L'(tau(A)), 11 = reserved (treated as 00).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  transformed word.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `in_data` and `in_mode`, clear the byte counter, go to SUB.
  - SUB: each cycle, substitute LANES bytes starting at byte 0 (MSB first) and advance the counter by LANES. After NSUB cycles, apply the linear transform, register the result into `out_data`, set `out_valid`, go to OUT.
  - OUT: hold `out_data`/`out_valid` stable until `out_ready`. On handshake, go to IDLE. If `in_valid` is also high in that cycle, the new request is accepted and the FSM goes straight to SUB.
- `in_ready` = (state==IDLE) || (state==OUT && `out_ready`). It is never high during SUB.
- Linear transforms, where B = tau(A) and <<< is 32-bit rotate-left:
  - L = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  - L' = B ^ B<<<13 ^ B<<<23.
- Latched mode 11 produces B unchanged. No error flag.
- Input changes while not accepted are ignored; latched values are used throughout.
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, counter 0, internal word register 0. `in_ready` is 1 once reset deasserts.
- Reset asserted mid-SUB or mid-OUT: the operation is discarded and no partial result appears.

## Timing
- Accept at edge k → `out_valid` high after edge k+NSUB: 1 cycle for LANES=4, 2 for LANES=2, 4 for LANES=1.
- Throughput with `out_ready` held high: one result per NSUB+1 cycles. The back-to-back accept in OUT removes the IDLE bubble.
- `out_data` is a register output. `in_ready` is combinational from state and `out_ready`; there is no path from `in_valid` to `in_ready`.
- S-box lookup plus byte write is one cycle. Linear transform plus output register is in the last SUB cycle.

## Structure
- Shared package `sm4_pkg`:
  - mode encodings MODE_TAU/MODE_L/MODE_LK;
  - `rotl32` function;
  - L and L' functions, reused by the cipher and key schedule.
- Sub-module: the existing `S_BOX` byte lookup, instantiated LANES times. A lane mux selects the bytes at counter offset.
- One file: FSM, counter (2 bits), 32-bit work register, output register.

## Test plan
- LANES=4, mode 00, A=0x00000000 → `out_data`=0xD6D6D6D6, `out_valid` one cycle after accept.
- LANES=1, mode 01, A=0x00000000 → 0x5B5B5B5B after 4 cycles. Mode 10, same A → 0x67676767.
- LANES=2, mode 00, A=0x01FF0000 → 0x9048D6D6 after 2 cycles. Mode 11, same A → same result.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_data` stable, `in_ready`=0. Release with `in_valid`=1 → next request accepted in the same cycle, with no idle cycle.
- Assert `rst` during SUB (LANES=1, cycle 2) → `out_valid` stays 0, state IDLE. The following request completes correctly.
- Random A/mode per LANES value, against the reference model: results match, and no handshake is lost or duplicated.
